// File: rtl/core_input_writer_pkg.sv
// Shared SHA job-input definitions: job byte layout, the core-facing hash state and
// the writer FSM encoding.
package core_input_writer_pkg;

  localparam int unsigned JOB_BYTES      = 44;
  localparam int unsigned MIDSTATE_BYTES = 32;
  localparam int unsigned W1_OFF         = 32;
  localparam int unsigned W2_OFF         = 36;
  localparam int unsigned W3_OFF         = 40;

  // Byte index width; covers any job up to 64 bytes.
  localparam int unsigned IDX_W = 6;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } HashState;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StIssue
  } writer_state_e;

  // The first byte received lands in the most significant position.
  function automatic logic [31:0] be_word(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/core_inputs_ifc.sv
// Bundle of job inputs presented to a hashing core; the writer drives, the core reads.
interface coreInputsIfc;

  logic                            valid;
  logic                            newblock;
  core_input_writer_pkg::HashState hashstate;
  logic [31:0]                     w1;
  logic [31:0]                     w2;
  logic [31:0]                     w3;

  modport writer (
    output valid,
    output newblock,
    output hashstate,
    output w1,
    output w2,
    output w3
  );

  modport reader (
    input valid,
    input newblock,
    input hashstate,
    input w1,
    input w2,
    input w3
  );

endinterface

// File: rtl/core_input_shadow_buffer.sv
// Byte-addressed staging storage for one job while it streams in from the host.
module core_input_shadow_buffer
  import core_input_writer_pkg::*;
#(
  parameter int unsigned NumBytes = JOB_BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  logic [IDX_W-1:0]         wr_idx_i,
  input  logic [7:0]               wr_data_i,
  output logic [NumBytes-1:0][7:0] bytes_o
);

  logic [NumBytes-1:0][7:0] mem_q;
  logic [NumBytes-1:0][7:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (clear_i) begin
      mem_d = '0;
    end else if (wr_en_i && (32'(wr_idx_i) < NumBytes)) begin
      mem_d[wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign bytes_o = mem_q;

endmodule

// File: rtl/core_input_writer.sv
// Collects a job byte stream into a shadow buffer and hands complete jobs to the core
// in a single cycle, pulsing newblock so the core restarts on the new job.
module core_input_writer #(
  parameter int unsigned JOB_BYTES = core_input_writer_pkg::JOB_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   data_i,
  input  logic         data_valid_i,
  output logic         data_ready_o,
  input  logic         abort_i,
  coreInputsIfc.writer out,
  output logic [15:0]  jobs_issued_o
);

  import core_input_writer_pkg::*;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(JOB_BYTES - 1);

  writer_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      jobs_q, jobs_d;

  logic accept;
  logic buf_wr;
  logic buf_clr;
  logic issue;

  logic [JOB_BYTES-1:0][7:0] job_bytes;

  logic [8*MIDSTATE_BYTES-1:0] hs_flat;
  HashState                    hs_new;
  logic [31:0]                 w1_new, w2_new, w3_new;

  HashState    hs_q;
  logic [31:0] w1_q, w2_q, w3_q;
  logic        valid_q;
  logic        newblock_q;

  core_input_shadow_buffer #(
    .NumBytes(JOB_BYTES)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (buf_clr),
    .wr_en_i  (buf_wr),
    .wr_idx_i (idx_q),
    .wr_data_i(data_i),
    .bytes_o  (job_bytes)
  );

  // Unpack the buffered job into core words; only sampled on issue.
  always_comb begin
    hs_flat = '0;
    for (int unsigned i = 0; i < MIDSTATE_BYTES / 4; i++) begin
      hs_flat[8*MIDSTATE_BYTES-1-32*i -: 32] = be_word(job_bytes[4*i], job_bytes[4*i+1],
                                                       job_bytes[4*i+2], job_bytes[4*i+3]);
    end
    hs_new = HashState'(hs_flat);
    w1_new = be_word(job_bytes[W1_OFF], job_bytes[W1_OFF+1],
                     job_bytes[W1_OFF+2], job_bytes[W1_OFF+3]);
    w2_new = be_word(job_bytes[W2_OFF], job_bytes[W2_OFF+1],
                     job_bytes[W2_OFF+2], job_bytes[W2_OFF+3]);
    w3_new = be_word(job_bytes[W3_OFF], job_bytes[W3_OFF+1],
                     job_bytes[W3_OFF+2], job_bytes[W3_OFF+3]);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_wr       = 1'b0;
    buf_clr      = 1'b0;
    issue        = 1'b0;
    data_ready_o = (state_q != StIssue);
    accept       = data_valid_i && data_ready_o;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          buf_wr  = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          buf_wr = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StIssue;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StIssue: begin
        issue   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including a pending issue and a same-cycle byte.
    if (abort_i) begin
      state_d = StIdle;
      idx_d   = '0;
      buf_wr  = 1'b0;
      buf_clr = 1'b1;
      issue   = 1'b0;
    end

    jobs_d = issue ? jobs_q + 16'd1 : jobs_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      jobs_q     <= '0;
      valid_q    <= 1'b0;
      newblock_q <= 1'b0;
      hs_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      w3_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      jobs_q     <= jobs_d;
      newblock_q <= issue;
      if (issue) begin
        valid_q <= 1'b1;
        hs_q    <= hs_new;
        w1_q    <= w1_new;
        w2_q    <= w2_new;
        w3_q    <= w3_new;
      end
    end
  end

  assign out.valid     = valid_q;
  assign out.newblock  = newblock_q;
  assign out.hashstate = hs_q;
  assign out.w1        = w1_q;
  assign out.w2        = w2_q;
  assign out.w3        = w3_q;
  assign jobs_issued_o = jobs_q;

endmodule

// File: tb/tb_core_input_writer.sv
// Directed bench for core_input_writer: job loading, issue timing, abort, gaps, wrap, reset.
module tb_core_input_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_i = 8'h00;
  logic        data_valid_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        data_ready_o;
  logic [15:0] jobs_issued_o;

  int total = 0;
  int bad = 0;
  int nb_cnt = 0;
  int bubble_cnt = 0;
  int unstable = 0;
  logic [351:0] prev_out;

  coreInputsIfc cif ();

  core_input_writer #(
    .JOB_BYTES(44)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .abort_i      (abort_i),
    .out          (cif),
    .jobs_issued_o(jobs_issued_o)
  );

  always #5 clk = ~clk;

  // Passive monitors: newblock pulses, ready bubbles, and output changes without newblock.
  always @(negedge clk) begin
    if (!rst) begin
      if (cif.newblock) nb_cnt++;
      if (!data_ready_o) bubble_cnt++;
      if (!cif.newblock && ({cif.hashstate, cif.w1, cif.w2, cif.w3} !== prev_out)) unstable++;
    end
    prev_out = {cif.hashstate, cif.w1, cif.w2, cif.w3};
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    data_valid_i = 1'b0;
    abort_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int guard;
    for (int g = 0; g < int'(gap); g++) begin
      data_valid_i = 1'b0;
      data_i = 8'($urandom);
      @(posedge clk);
      #1;
    end
    data_i = b;
    data_valid_i = 1'b1;
    guard = 0;
    while (data_ready_o !== 1'b1 && guard < 8) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 8) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got=%0b exp=1", data_ready_o);
    end
    @(posedge clk);
    #1;
    data_valid_i = 1'b0;
  endtask

  task automatic send_range(input logic [7:0] base, input int first, input int last,
                            input int unsigned max_gap);
    for (int i = first; i <= last; i++) begin
      send_byte(base + 8'(i), (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cif.valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", cif.valid); end
    total++; if (cif.newblock !== 1'b0) begin bad++; $display("FAIL rst_newblock got=%0b exp=0", cif.newblock); end
    total++; if (cif.hashstate !== 256'h0) begin bad++; $display("FAIL rst_hashstate got=%h exp=0", cif.hashstate); end
    total++; if ({cif.w1, cif.w2, cif.w3} !== 96'h0) begin bad++; $display("FAIL rst_w got=%h exp=0", {cif.w1, cif.w2, cif.w3}); end
    total++; if (jobs_issued_o !== 16'h0) begin bad++; $display("FAIL rst_jobs got=%h exp=0000", jobs_issued_o); end
    total++; if (data_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", data_ready_o); end
    total++; if (dut.idx_q !== 6'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", dut.idx_q); end
  endtask

  task automatic test_single_job();
    int nb0;
    nb0 = nb_cnt;
    send_range(8'h00, 0, 43, 0);
    total++; if (data_ready_o !== 1'b0) begin bad++; $display("FAIL single_issue_ready got=%0b exp=0", data_ready_o); end
    total++; if (cif.hashstate.a !== 32'h0) begin bad++; $display("FAIL single_early_a got=%h exp=00000000", cif.hashstate.a); end
    @(posedge clk); #1;
    total++; if (cif.newblock !== 1'b1) begin bad++; $display("FAIL single_nb got=%0b exp=1", cif.newblock); end
    total++; if (cif.hashstate.a !== 32'h00010203) begin bad++; $display("FAIL single_a got=%h exp=00010203", cif.hashstate.a); end
    total++; if (cif.hashstate.h !== 32'h1C1D1E1F) begin bad++; $display("FAIL single_h got=%h exp=1c1d1e1f", cif.hashstate.h); end
    total++; if (cif.hashstate.e !== 32'h10111213) begin bad++; $display("FAIL single_e got=%h exp=10111213", cif.hashstate.e); end
    total++; if (cif.w1 !== 32'h20212223) begin bad++; $display("FAIL single_w1 got=%h exp=20212223", cif.w1); end
    total++; if (cif.w2 !== 32'h24252627) begin bad++; $display("FAIL single_w2 got=%h exp=24252627", cif.w2); end
    total++; if (cif.w3 !== 32'h28292A2B) begin bad++; $display("FAIL single_w3 got=%h exp=28292a2b", cif.w3); end
    total++; if (cif.valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", cif.valid); end
    total++; if (jobs_issued_o !== 16'd1) begin bad++; $display("FAIL single_jobs got=%h exp=0001", jobs_issued_o); end
    @(posedge clk); #1;
    total++; if (cif.newblock !== 1'b0) begin bad++; $display("FAIL single_nb_fall got=%0b exp=0", cif.newblock); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (cif.valid !== 1'b1) begin bad++; $display("FAIL single_valid_hold got=%0b exp=1", cif.valid); end
    total++; if (nb_cnt - nb0 !== 1) begin bad++; $display("FAIL single_nb_count got=%0d exp=1", nb_cnt - nb0); end
  endtask

  task automatic test_back_to_back();
    int nb0, b0, u0;
    do_reset();
    nb0 = nb_cnt; b0 = bubble_cnt; u0 = unstable;
    send_range(8'h40, 0, 43, 0);
    send_range(8'h80, 0, 9, 0);
    total++; if (cif.hashstate.a !== 32'h40414243) begin bad++; $display("FAIL b2b_hold_a got=%h exp=40414243", cif.hashstate.a); end
    total++; if (cif.w3 !== 32'h68696A6B) begin bad++; $display("FAIL b2b_hold_w3 got=%h exp=68696a6b", cif.w3); end
    total++; if (jobs_issued_o !== 16'd1) begin bad++; $display("FAIL b2b_jobs1 got=%h exp=0001", jobs_issued_o); end
    send_range(8'h80, 10, 43, 0);
    @(posedge clk); #1;
    total++; if (cif.newblock !== 1'b1) begin bad++; $display("FAIL b2b_nb2 got=%0b exp=1", cif.newblock); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (bubble_cnt - b0 !== 2) begin bad++; $display("FAIL b2b_bubbles got=%0d exp=2", bubble_cnt - b0); end
    total++; if (nb_cnt - nb0 !== 2) begin bad++; $display("FAIL b2b_nb_count got=%0d exp=2", nb_cnt - nb0); end
    total++; if (unstable - u0 !== 0) begin bad++; $display("FAIL b2b_stable got=%0d exp=0", unstable - u0); end
    total++; if (jobs_issued_o !== 16'd2) begin bad++; $display("FAIL b2b_jobs2 got=%h exp=0002", jobs_issued_o); end
    total++; if (cif.hashstate.a !== 32'h80818283) begin bad++; $display("FAIL b2b_a got=%h exp=80818283", cif.hashstate.a); end
    total++; if (cif.hashstate.h !== 32'h9C9D9E9F) begin bad++; $display("FAIL b2b_h got=%h exp=9c9d9e9f", cif.hashstate.h); end
    total++; if (cif.w3 !== 32'hA8A9AAAB) begin bad++; $display("FAIL b2b_w3 got=%h exp=a8a9aaab", cif.w3); end
  endtask

  task automatic test_abort();
    int u0;
    u0 = unstable;
    send_range(8'h10, 0, 19, 0);
    data_i = 8'hEE; data_valid_i = 1'b1; abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0; data_valid_i = 1'b0;
    total++; if (dut.idx_q !== 6'd0) begin bad++; $display("FAIL abort_idx got=%0d exp=0", dut.idx_q); end
    total++; if (data_ready_o !== 1'b1) begin bad++; $display("FAIL abort_ready got=%0b exp=1", data_ready_o); end
    total++; if (cif.hashstate.a !== 32'h80818283) begin bad++; $display("FAIL abort_keep_a got=%h exp=80818283", cif.hashstate.a); end
    total++; if (jobs_issued_o !== 16'd2) begin bad++; $display("FAIL abort_jobs got=%h exp=0002", jobs_issued_o); end
    send_range(8'hC0, 0, 43, 0);
    @(posedge clk); #1;
    total++; if (cif.newblock !== 1'b1) begin bad++; $display("FAIL abort_full_nb got=%0b exp=1", cif.newblock); end
    total++; if (cif.hashstate.a !== 32'hC0C1C2C3) begin bad++; $display("FAIL abort_full_a got=%h exp=c0c1c2c3", cif.hashstate.a); end
    total++; if (cif.w1 !== 32'hE0E1E2E3) begin bad++; $display("FAIL abort_full_w1 got=%h exp=e0e1e2e3", cif.w1); end
    total++; if (cif.w3 !== 32'hE8E9EAEB) begin bad++; $display("FAIL abort_full_w3 got=%h exp=e8e9eaeb", cif.w3); end
    total++; if (jobs_issued_o !== 16'd3) begin bad++; $display("FAIL abort_full_jobs got=%h exp=0003", jobs_issued_o); end
    // Abort landing exactly in the issue cycle cancels that issue.
    send_range(8'h20, 0, 43, 0);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    total++; if (cif.newblock !== 1'b0) begin bad++; $display("FAIL abort_issue_nb got=%0b exp=0", cif.newblock); end
    total++; if (jobs_issued_o !== 16'd3) begin bad++; $display("FAIL abort_issue_jobs got=%h exp=0003", jobs_issued_o); end
    total++; if (cif.hashstate.a !== 32'hC0C1C2C3) begin bad++; $display("FAIL abort_issue_a got=%h exp=c0c1c2c3", cif.hashstate.a); end
    total++; if (cif.valid !== 1'b1) begin bad++; $display("FAIL abort_issue_valid got=%0b exp=1", cif.valid); end
    total++; if (unstable - u0 !== 0) begin bad++; $display("FAIL abort_stable got=%0d exp=0", unstable - u0); end
  endtask

  task automatic test_gaps();
    int nb0;
    do_reset();
    nb0 = nb_cnt;
    send_range(8'h00, 0, 43, 3);
    @(posedge clk); #1;
    total++; if (cif.newblock !== 1'b1) begin bad++; $display("FAIL gaps_nb got=%0b exp=1", cif.newblock); end
    total++; if (cif.hashstate !== 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F) begin
      bad++; $display("FAIL gaps_hashstate got=%h exp=000102..1f", cif.hashstate);
    end
    total++; if ({cif.w1, cif.w2, cif.w3} !== 96'h202122232425262728292A2B) begin
      bad++; $display("FAIL gaps_w got=%h exp=202122232425262728292a2b", {cif.w1, cif.w2, cif.w3});
    end
    repeat (4) @(posedge clk);
    #1;
    total++; if (nb_cnt - nb0 !== 1) begin bad++; $display("FAIL gaps_nb_count got=%0d exp=1", nb_cnt - nb0); end
    total++; if (jobs_issued_o !== 16'd1) begin bad++; $display("FAIL gaps_jobs got=%h exp=0001", jobs_issued_o); end
  endtask

  task automatic test_wrap();
    force dut.jobs_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.jobs_q;
    @(posedge clk); #1;
    total++; if (jobs_issued_o !== 16'hFFFF) begin bad++; $display("FAIL wrap_preset got=%h exp=ffff", jobs_issued_o); end
    send_range(8'h30, 0, 43, 0);
    @(posedge clk); #1;
    total++; if (cif.newblock !== 1'b1) begin bad++; $display("FAIL wrap_nb got=%0b exp=1", cif.newblock); end
    total++; if (jobs_issued_o !== 16'h0000) begin bad++; $display("FAIL wrap_jobs got=%h exp=0000", jobs_issued_o); end
  endtask

  task automatic test_rst_mid();
    send_range(8'h50, 0, 29, 0);
    data_i = 8'h6E; data_valid_i = 1'b1; abort_i = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; abort_i = 1'b0; data_valid_i = 1'b0;
    total++; if (cif.valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b exp=0", cif.valid); end
    total++; if (dut.idx_q !== 6'd0) begin bad++; $display("FAIL rstmid_idx got=%0d exp=0", dut.idx_q); end
    total++; if (jobs_issued_o !== 16'h0) begin bad++; $display("FAIL rstmid_jobs got=%h exp=0000", jobs_issued_o); end
    total++; if (cif.hashstate.a !== 32'h0) begin bad++; $display("FAIL rstmid_a got=%h exp=00000000", cif.hashstate.a); end
    total++; if (data_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", data_ready_o); end
    send_range(8'h50, 0, 43, 0);
    @(posedge clk); #1;
    total++; if (cif.newblock !== 1'b1) begin bad++; $display("FAIL rstmid_nb got=%0b exp=1", cif.newblock); end
    total++; if (cif.hashstate.a !== 32'h50515253) begin bad++; $display("FAIL rstmid_full_a got=%h exp=50515253", cif.hashstate.a); end
    total++; if (cif.hashstate.h !== 32'h6C6D6E6F) begin bad++; $display("FAIL rstmid_full_h got=%h exp=6c6d6e6f", cif.hashstate.h); end
    total++; if ({cif.w1, cif.w2, cif.w3} !== 96'h707172737475767778797A7B) begin
      bad++; $display("FAIL rstmid_full_w got=%h exp=707172737475767778797a7b", {cif.w1, cif.w2, cif.w3});
    end
    total++; if (jobs_issued_o !== 16'd1) begin bad++; $display("FAIL rstmid_full_jobs got=%h exp=0001", jobs_issued_o); end
    total++; if (cif.valid !== 1'b1) begin bad++; $display("FAIL rstmid_full_valid got=%0b exp=1", cif.valid); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_abort();
    test_gaps();
    test_wrap();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_input_writer.md
CORE_INPUT_WRITER -- requirements
Module: core_input_writer

Interface
REQ-001 Parameter JOB_BYTES, default 44, bytes per job: 32 midstate bytes plus 12 tail bytes.
REQ-002 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port data_i, input, 8, job byte stream from host.
REQ-005 Port data_valid_i, input, 1, data_i valid this cycle.
REQ-006 Port data_ready_o, output, 1, block accepts data_i this cycle.
REQ-007 Port abort_i, input, 1, discard any partially loaded job.
REQ-008 Port out, coreInputsIfc.writer modport; drives valid, newblock, hashstate (HashState), w1, w2, w3 (each 32 bits) into the core.
REQ-009 Port jobs_issued_o, output, 16, count of jobs presented to the core.

Function
REQ-010 A byte transfers only when data_valid_i and data_ready_o are both 1 in the same cycle.
REQ-011 Byte order: bytes 0-31 form hashstate words a..h, bytes 32-35 w1, 36-39 w2, 40-43 w3; each word big-endian (first byte lands in bits 31:24).
REQ-012 Incoming bytes go into a shadow buffer; the registers driving out change only at issue.
REQ-013 FSM states: IDLE (no byte of a job received), LOAD (1..JOB_BYTES-1 bytes received), ISSUE (full job buffered).
REQ-014 IDLE->LOAD on the first accepted byte; LOAD->ISSUE on acceptance of byte JOB_BYTES-1; ISSUE->IDLE after one cycle.
REQ-015 A 6-bit byte index increments per accepted byte and returns to 0 on the ISSUE transition.
REQ-016 In ISSUE, the shadow buffer is copied to the output registers, so out.hashstate, w1, w2 and w3 take the new values in the cycle after ISSUE.
REQ-017 out.newblock is 1 for exactly that first cycle with the new values and 0 otherwise.
REQ-018 out.valid rises with the first newblock and then stays 1, including while a subsequent job loads; the core keeps iterating on the current job.
REQ-019 data_ready_o is 0 in ISSUE and 1 in IDLE and LOAD, giving one bubble per job.
REQ-020 abort_i=1 forces IDLE with index 0 next cycle and discards the shadow buffer; any byte accepted in that same cycle is also discarded.
REQ-021 abort_i does not change the output registers, out.valid or jobs_issued_o.
REQ-022 abort_i in ISSUE takes priority: the issue is cancelled and jobs_issued_o does not increment.
REQ-023 jobs_issued_o increments by 1 on each ISSUE and wraps from 0xFFFF to 0x0000.

Reset
REQ-024 rst returns the FSM to IDLE and sets the byte index to 0.
REQ-025 rst clears out.valid, out.newblock, hashstate, w1, w2, w3 and jobs_issued_o to 0, and sets data_ready_o to 1 from the first cycle after reset.
REQ-026 rst asserted mid-LOAD discards the partial job; rst has priority over abort_i and data_valid_i.

Structure
REQ-027 HashState and coreInputsIfc are the existing shared definitions; JOB_BYTES and the byte-offset constants (MIDSTATE_BYTES=32, W1_OFF=32, W2_OFF=36, W3_OFF=40) are placed in the shared SHA package.
REQ-028 One sub-module, core_input_shadow_buffer, holds the 44-byte byte-addressed shadow storage; the FSM, counters and output registers stay in core_input_writer.

Verification
REQ-029 Reset, then stream bytes 0x00..0x2B back-to-back -> hashstate.a=0x00010203, h=0x1C1D1E1F, w1=0x20212223, w3=0x28292A2B; newblock a single-cycle pulse; valid=1 thereafter; jobs_issued_o=1.
REQ-030 Two jobs back-to-back -> data_ready_o=0 for exactly one cycle per job; first-job outputs remain stable while the second job loads; second newblock pulse; jobs_issued_o=2.
REQ-031 Load 20 bytes, pulse abort_i, then send a full 44-byte job -> only the full job is issued; earlier outputs stay unchanged until that issue.
REQ-032 Random gaps in data_valid_i -> outputs bit-identical to the gap-free case; exactly one newblock pulse.
REQ-033 Preset 65535 jobs, then issue one more -> jobs_issued_o=0x0000.
REQ-034 rst asserted at byte 30 of a job -> valid=0 and index=0; a subsequent full job is issued correctly.
